// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_JUMP,
        SEL_BR,
        SEL_SEQ
    } pc_sel_e;

    // Clears the low log2(inc) bits; callers truncate to their address width.
    function automatic logic [63:0] align_mask(input int unsigned inc);
        return ~(64'(inc) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack: when full, a push overwrites the oldest entry.
module pc_return_stack #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [ADDR_W-1:0]       data_i,
    output logic [ADDR_W-1:0]       top_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  top_q, top_d, rd_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, empty;

    assign full       = (count_q == FULL);
    assign empty      = (count_q == '0);
    assign rd_ptr     = top_q - 1'b1;
    assign top_data_o = mem_q[rd_ptr];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // With DEPTH a power of two, top wraps naturally onto the oldest slot when full.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_i) begin
            top_d = top_q + 1'b1;
            if (full) ovf_d = 1'b1;
            else      count_d = count_q + 1'b1;
        end else if (pop_i && !empty) begin
            top_d   = top_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[top_q] <= data_i;
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch program counter with branch/jump/call/return redirects and a return-address stack.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                OFF_W        = 16,
    parameter int                INC          = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        branch,
    input  logic [OFF_W-1:0]            offset,
    input  logic                        jump,
    input  logic                        call,
    input  logic                        ret,
    input  logic [ADDR_W-1:0]           target,
    output logic [ADDR_W-1:0]           address,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(align_mask(INC));

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_pc, br_pc, tgt_al, ras_top;
    logic              ras_empty, push, pop;
    logic              uflow_q, uflow_d;

    always_comb begin
        sel = SEL_SEQ;
        if      (stall)  sel = SEL_HOLD;
        else if (ret)    sel = SEL_RET;
        else if (call)   sel = SEL_CALL;
        else if (jump)   sel = SEL_JUMP;
        else if (branch) sel = SEL_BR;
    end

    assign seq_pc    = pc_q + ADDR_W'(INC);
    assign br_pc     = (pc_q + {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset}) & MASK;
    assign tgt_al    = target & MASK;
    assign ras_empty = (ras_count == '0);
    assign push      = (sel == SEL_CALL);
    assign pop       = (sel == SEL_RET) && !ras_empty;
    assign uflow_d   = (sel == SEL_RET) && ras_empty;

    // A return with nothing stacked falls through to the next sequential address.
    always_comb begin
        pc_d = seq_pc;
        case (sel)
            SEL_HOLD: pc_d = pc_q;
            SEL_RET:  pc_d = ras_empty ? seq_pc : ras_top;
            SEL_CALL: pc_d = tgt_al;
            SEL_JUMP: pc_d = tgt_al;
            SEL_BR:   pc_d = br_pc;
            default:  pc_d = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            uflow_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            uflow_q <= uflow_d;
        end
    end

    pc_return_stack #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ras (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .push_i     (push),
        .pop_i      (pop),
        .data_i     (seq_pc),
        .top_data_o (ras_top),
        .count_o    (ras_count),
        .overflow_o (ras_overflow)
    );

    assign address       = pc_q;
    assign ras_underflow = uflow_q;

endmodule
